req_encoder4to2: RTL and testbench
==================================

// Module: req_encoder4to2
// PURPOSE
//  Counterpart of the 2-to-4 active-low decoder: a registered 4-to-2 request encoder.
//  - Samples four active-low request lines (same polarity as decoder outputs).
//  - Latches each request into a pending bit.
//  - Offers one 2-bit code at a time on a valid/ready handshake, clearing that pending bit on accept.
//  - Sits between decoded select/strobe lines and a consumer that needs a binary index.
// PARAMETERS
//  EDGE_DET  1  1: capture on falling edge of y_n[k]; 0: capture while y_n[k] is low (level)
//  RR_MODE   0  0: fixed priority, line 3 highest, line 0 lowest; 1: round-robin
// PORTS
//  clk      in   1  rising-edge clock
//  rst_n    in   1  asynchronous active-low reset
//  en       in   1  active-low capture enable; en=1 blocks new captures, pending bits still drain
//  y_n      in   4  active-low request lines, synchronous to clk
//  ready    in   1  consumer accepts code when valid&ready at a rising edge
//  code     out  2  encoded index of the offered request
//  valid    out  1  code is valid
//  pend     out  4  pending-request register (bit k = line k pending)
//  overrun  out  1  one-cycle pulse: new event on a line already pending (EDGE_DET=1 only)
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous, any state):
//   - code=00, valid=0, pend=0000, overrun=0.
//   - y_n_q=1111, last=11, state=IDLE.
//  Event detection, per line k:
//   - EDGE_DET=1: evt[k] = y_n_q[k] & ~y_n[k]; y_n_q <= y_n every cycle.
//   - EDGE_DET=0: evt[k] = ~y_n[k].
//   - cap[k] = evt[k] & ~en.
//  Pending update, per edge:
//   - pend[k] <= (pend[k] & ~clr[k]) | cap[k].
//   - clr[k] = valid & ready & (code==k).
//   - Set wins over clear in the same cycle.
//  overrun, registered:
//   - Asserted for 1 cycle if cap[k] & pend[k] & ~clr[k] for any k.
//   - Tied to 0 when EDGE_DET=0.
//  FSM states:
//   - IDLE: valid=0. If pend!=0000, next edge: code<=sel, valid<=1, go to OFFER.
//   - OFFER: code and valid held stable while ready=0; changes in pend never alter code.
//     On valid&ready: clr[code], valid<=0, last<=code, return to IDLE.
//  Selection, sel:
//   - RR_MODE=0: highest-index set bit of pend.
//   - RR_MODE=1: first set bit searching from last+1 upward, wrapping 3->0.
//  Latency and throughput:
//   - Line sampled low/falling at edge t0 -> pend set after t0 -> valid=1 after t1.
//   - Minimum 2 cycles from request to valid.
//   - One bubble cycle in IDLE after each accept; max throughput is 1 code per 2 cycles.
//  Level mode: a line held low re-pends on the edge it is cleared; this is intended.
//  Bounds: code is always a line whose pend bit was 1 when it entered OFFER; valid never asserts with pend=0000.
// TESTING
//  T1 reset: assert rst_n=0 mid-OFFER, no clock edge -> valid=0, code=00, pend=0000 immediately.
//  T2 single (EDGE_DET=1): en=0, ready=1, y_n=1101 for 1 cycle -> pend=0010, then valid=1 code=01 for 1 cycle, then pend=0000.
//  T3 fixed priority: y_n=0110 for 1 cycle, ready=1 -> code 11 accepted, then code 00; pend 1001 -> 0001 -> 0000.
//  T4 round-robin (RR_MODE=1): y_n=0000 for 1 cycle after reset, ready=1 -> codes 00, 01, 10, 11 in order.
//  T5 backpressure: code=00 offered, ready=0 for 5 cycles, pulse line 3 -> code stays 00, valid stays 1, pend=1001; ready=1 -> 00 accepted, then 11 offered.
//  T6 gating/overrun: en=1 with falling edge on y_n[2] -> pend=0000. Then en=0, two falling edges on y_n[2] while ready=0 -> overrun=1 for exactly 1 cycle.

Source files
------------

// File: rtl/req_encoder4to2_if.sv
// Handshake/request bundle for req_encoder4to2: request lines and enable in,
// encoded code with valid/ready handshake, pending and overrun status out.
interface req_encoder4to2_if;
    logic       en;
    logic [3:0] y_n;
    logic       ready;
    logic [1:0] code;
    logic       valid;
    logic [3:0] pend;
    logic       overrun;

    modport master (
        output en, y_n, ready,
        input  code, valid, pend, overrun
    );

    modport slave (
        input  en, y_n, ready,
        output code, valid, pend, overrun
    );
endinterface

// File: rtl/req_encoder4to2.sv
// Registered 4-to-2 request encoder: latches active-low request lines into pending
// bits and offers one binary index at a time on a valid/ready handshake.
module req_encoder4to2 #(
    parameter int unsigned EDGE_DET = 1,
    parameter int unsigned RR_MODE  = 0
) (
    input logic              clk,
    input logic              rst_n,
    req_encoder4to2_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;

    logic [0:0] state_q, state_d;
    logic [3:0] y_n_q;
    logic [3:0] pend_q, pend_d;
    logic [1:0] code_q, code_d;
    logic [1:0] last_q, last_d;
    logic       overrun_q, overrun_d;

    logic [3:0] evt, cap, clr;
    logic [1:0] sel, idx;
    logic       found;
    logic       accept;

    assign accept = (state_q == OFFER) && bus.ready;

    always_comb begin
        evt = (EDGE_DET != 0) ? (y_n_q & ~bus.y_n) : ~bus.y_n;
        cap = evt & {4{~bus.en}};
        clr = '0;
        if (accept) clr[code_q] = 1'b1;
        // Set is ORed in after the clear so a same-cycle capture wins.
        pend_d    = (pend_q & ~clr) | cap;
        overrun_d = (EDGE_DET != 0) ? |(cap & pend_q & ~clr) : 1'b0;
    end

    // Round-robin search starts one past the last accepted line; i=4 wraps back to last.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        if (RR_MODE == 0) begin
            for (int unsigned i = 0; i < 4; i++)
                if (pend_q[i]) sel = 2'(i);
        end else begin
            for (int unsigned i = 1; i <= 4; i++) begin
                idx = last_q + 2'(i);
                if (!found && pend_q[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pend_q != 4'b0000) begin
                    code_d  = sel;
                    state_d = OFFER;
                end
            end
            default: begin
                if (bus.ready) begin
                    last_d  = code_q;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            y_n_q     <= 4'b1111;
            pend_q    <= '0;
            code_q    <= '0;
            last_q    <= 2'b11;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_n_q     <= bus.y_n;
            pend_q    <= pend_d;
            code_q    <= code_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.code    = code_q;
    assign bus.valid   = (state_q == OFFER);
    assign bus.pend    = pend_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_req_encoder4to2.sv
// Directed bench for req_encoder4to2: fixed-priority edge, round-robin edge and
// level-mode instances driven through their own interfaces.
module tb_req_encoder4to2;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    req_encoder4to2_if if0 ();
    req_encoder4to2_if if1 ();
    req_encoder4to2_if if2 ();

    req_encoder4to2 #(.EDGE_DET(1), .RR_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    req_encoder4to2 #(.EDGE_DET(1), .RR_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    req_encoder4to2 #(.EDGE_DET(0), .RR_MODE(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        checks++; if (if0.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if0.valid); end
        checks++; if (if0.code !== 2'b00) begin errors++; $display("FAIL reset_code got %b exp 00", if0.code); end
        checks++; if (if0.pend !== 4'b0000) begin errors++; $display("FAIL reset_pend got %b exp 0000", if0.pend); end
        checks++; if (if0.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", if0.overrun); end
    endtask

    task automatic test_single;
        if0.en = 1'b0; if0.ready = 1'b1; if0.y_n = 4'b1101;
        @(negedge clk);
        checks++; if (if0.pend !== 4'b0010) begin errors++; $display("FAIL single_pend got %b exp 0010", if0.pend); end
        checks++; if (if0.valid !== 1'b0) begin errors++; $display("FAIL single_latency got %b exp 0", if0.valid); end
        if0.y_n = 4'b1111;
        @(negedge clk);
        checks++; if (if0.valid !== 1'b1 || if0.code !== 2'b01) begin errors++; $display("FAIL single_offer got v%b c%b exp v1 c01", if0.valid, if0.code); end
        @(negedge clk);
        checks++; if (if0.valid !== 1'b0 || if0.pend !== 4'b0000) begin errors++; $display("FAIL single_drain got v%b p%b exp v0 p0000", if0.valid, if0.pend); end
    endtask

    task automatic test_fixed_priority;
        if0.y_n = 4'b0110;
        @(negedge clk);
        if0.y_n = 4'b1111;
        checks++; if (if0.pend !== 4'b1001) begin errors++; $display("FAIL prio_pend got %b exp 1001", if0.pend); end
        @(negedge clk);
        checks++; if (if0.valid !== 1'b1 || if0.code !== 2'b11) begin errors++; $display("FAIL prio_first got v%b c%b exp v1 c11", if0.valid, if0.code); end
        @(negedge clk);
        checks++; if (if0.valid !== 1'b0 || if0.pend !== 4'b0001) begin errors++; $display("FAIL prio_bubble got v%b p%b exp v0 p0001", if0.valid, if0.pend); end
        @(negedge clk);
        checks++; if (if0.valid !== 1'b1 || if0.code !== 2'b00) begin errors++; $display("FAIL prio_second got v%b c%b exp v1 c00", if0.valid, if0.code); end
        @(negedge clk);
        checks++; if (if0.pend !== 4'b0000) begin errors++; $display("FAIL prio_drain got %b exp 0000", if0.pend); end
    endtask

    task automatic test_async_reset;
        if0.ready = 1'b0; if0.y_n = 4'b1011;
        @(negedge clk);
        if0.y_n = 4'b1111;
        @(negedge clk);
        checks++; if (if0.valid !== 1'b1 || if0.code !== 2'b10) begin errors++; $display("FAIL rst_setup got v%b c%b exp v1 c10", if0.valid, if0.code); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if0.valid !== 1'b0 || if0.code !== 2'b00 || if0.pend !== 4'b0000) begin errors++; $display("FAIL rst_async got v%b c%b p%b exp v0 c00 p0000", if0.valid, if0.code, if0.pend); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin;
        if1.en = 1'b0; if1.ready = 1'b1; if1.y_n = 4'b0000;
        @(negedge clk);
        if1.y_n = 4'b1111;
        checks++; if (if1.pend !== 4'b1111) begin errors++; $display("FAIL rr_pend got %b exp 1111", if1.pend); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (if1.valid !== 1'b1 || if1.code !== 2'(k)) begin errors++; $display("FAIL rr_order%0d got v%b c%b exp v1 c%0d", k, if1.valid, if1.code, k); end
            @(negedge clk);
        end
        if1.y_n = 4'b0101;
        @(negedge clk);
        if1.y_n = 4'b1111;
        @(negedge clk);
        checks++; if (if1.valid !== 1'b1 || if1.code !== 2'b01) begin errors++; $display("FAIL rr_wrap got v%b c%b exp v1 c01", if1.valid, if1.code); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (if1.valid !== 1'b1 || if1.code !== 2'b11) begin errors++; $display("FAIL rr_wrap2 got v%b c%b exp v1 c11", if1.valid, if1.code); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        if0.en = 1'b0; if0.ready = 1'b0; if0.y_n = 4'b1110;
        @(negedge clk);
        if0.y_n = 4'b1111;
        @(negedge clk);
        if0.y_n = 4'b0111;
        @(negedge clk);
        if0.y_n = 4'b1111;
        repeat (3) @(negedge clk);
        checks++; if (if0.valid !== 1'b1 || if0.code !== 2'b00 || if0.pend !== 4'b1001) begin errors++; $display("FAIL bp_hold got v%b c%b p%b exp v1 c00 p1001", if0.valid, if0.code, if0.pend); end
        if0.ready = 1'b1;
        @(negedge clk);
        checks++; if (if0.valid !== 1'b0 || if0.pend !== 4'b1000) begin errors++; $display("FAIL bp_accept got v%b p%b exp v0 p1000", if0.valid, if0.pend); end
        @(negedge clk);
        checks++; if (if0.valid !== 1'b1 || if0.code !== 2'b11) begin errors++; $display("FAIL bp_next got v%b c%b exp v1 c11", if0.valid, if0.code); end
        @(negedge clk);
    endtask

    task automatic test_gating_overrun;
        if0.en = 1'b1; if0.ready = 1'b1; if0.y_n = 4'b1011;
        @(negedge clk);
        if0.y_n = 4'b1111;
        @(negedge clk);
        checks++; if (if0.pend !== 4'b0000 || if0.valid !== 1'b0) begin errors++; $display("FAIL gate_pend got p%b v%b exp p0000 v0", if0.pend, if0.valid); end
        if0.en = 1'b0; if0.ready = 1'b0; if0.y_n = 4'b1011;
        @(negedge clk);
        if0.y_n = 4'b1111;
        checks++; if (if0.pend !== 4'b0100 || if0.overrun !== 1'b0) begin errors++; $display("FAIL ovr_first got p%b o%b exp p0100 o0", if0.pend, if0.overrun); end
        @(negedge clk);
        if0.y_n = 4'b1011;
        @(negedge clk);
        if0.y_n = 4'b1111;
        checks++; if (if0.overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b exp 1", if0.overrun); end
        @(negedge clk);
        checks++; if (if0.overrun !== 1'b0 || if0.code !== 2'b10) begin errors++; $display("FAIL ovr_single got o%b c%b exp o0 c10", if0.overrun, if0.code); end
        if0.ready = 1'b1;
        @(negedge clk);
        checks++; if (if0.pend !== 4'b0000) begin errors++; $display("FAIL ovr_drain got %b exp 0000", if0.pend); end
    endtask

    task automatic test_level_mode;
        if2.en = 1'b0; if2.ready = 1'b0; if2.y_n = 4'b1110;
        repeat (4) @(negedge clk);
        checks++; if (if2.overrun !== 1'b0 || if2.valid !== 1'b1 || if2.code !== 2'b00) begin errors++; $display("FAIL lvl_hold got o%b v%b c%b exp o0 v1 c00", if2.overrun, if2.valid, if2.code); end
        if2.ready = 1'b1;
        @(negedge clk);
        checks++; if (if2.pend !== 4'b0001 || if2.valid !== 1'b0) begin errors++; $display("FAIL lvl_repend got p%b v%b exp p0001 v0", if2.pend, if2.valid); end
        if2.y_n = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        checks++; if (if2.pend !== 4'b0000 || if2.valid !== 1'b0) begin errors++; $display("FAIL lvl_drain got p%b v%b exp p0000 v0", if2.pend, if2.valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        if0.en = 1'b0; if0.y_n = 4'b1111; if0.ready = 1'b0;
        if1.en = 1'b0; if1.y_n = 4'b1111; if1.ready = 1'b0;
        if2.en = 1'b0; if2.y_n = 4'b1111; if2.ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_single;
        test_fixed_priority;
        test_async_reset;
        test_reset;
        test_round_robin;
        test_backpressure;
        test_gating_overrun;
        test_level_mode;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
